// File: rtl/intersection_controller.sv
// Two-road intersection sequencer: main/side signal heads plus pedestrian WALK,
// main road resting on green, timed clearance phases between conflicting greens.
module intersection_controller #(
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned MAIN_MIN_GREEN  = 20,
    parameter int unsigned SIDE_GREEN_TIME = 10,
    parameter int unsigned YELLOW_TIME     = 4,
    parameter int unsigned ALL_RED_TIME    = 2,
    parameter int unsigned WALK_TIME       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       side_req,
    input  logic       ped_req,
    output logic       main_red,
    output logic       main_yellow,
    output logic       main_green,
    output logic       side_red,
    output logic       side_yellow,
    output logic       side_green,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        ALL_RED_M   = 3'd0,
        MAIN_GREEN  = 3'd1,
        MAIN_YELLOW = 3'd2,
        ALL_RED_S   = 3'd3,
        PED_WALK    = 3'd4,
        SIDE_GREEN  = 3'd5,
        SIDE_YELLOW = 3'd6
    } state_t;

    // Last timer value of each timed state (state lasts exactly D cycles)
    localparam logic [CNT_W-1:0] MIN_GREEN_LAST  = CNT_W'(MAIN_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] SIDE_GREEN_LAST = CNT_W'(SIDE_GREEN_TIME - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST     = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] ALL_RED_LAST    = CNT_W'(ALL_RED_TIME - 1);
    localparam logic [CNT_W-1:0] WALK_LAST       = CNT_W'(WALK_TIME - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] timer, timer_next;
    logic             ped_next;
    logic [2:0]       main_next, side_next;
    logic             walk_next;

    // State, timer, pending request and registered lamp drivers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ALL_RED_M;
            timer       <= '0;
            ped_pending <= 1'b0;
            main_red    <= 1'b1;
            main_yellow <= 1'b0;
            main_green  <= 1'b0;
            side_red    <= 1'b1;
            side_yellow <= 1'b0;
            side_green  <= 1'b0;
            walk        <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            ped_pending <= ped_next;
            {main_red, main_yellow, main_green} <= main_next;
            {side_red, side_yellow, side_green} <= side_next;
            walk        <= walk_next;
        end
    end

    // Next-state, timer and pedestrian latch; lamps decoded from the next state
    always_comb begin
        state_next = state;
        timer_next = timer + CNT_W'(1);
        ped_next   = ped_pending;
        main_next  = 3'b100;
        side_next  = 3'b100;
        walk_next  = 1'b0;

        case (state)
            ALL_RED_M:   if (timer == ALL_RED_LAST) state_next = MAIN_GREEN;
            MAIN_GREEN:  if (timer == MIN_GREEN_LAST && (side_req || ped_pending))
                             state_next = MAIN_YELLOW;
            MAIN_YELLOW: if (timer == YELLOW_LAST) state_next = ALL_RED_S;
            ALL_RED_S:   if (timer == ALL_RED_LAST)
                             state_next = ped_pending ? PED_WALK : SIDE_GREEN;
            PED_WALK:    if (timer == WALK_LAST)
                             state_next = side_req ? SIDE_GREEN : ALL_RED_M;
            SIDE_GREEN:  if (timer == SIDE_GREEN_LAST) state_next = SIDE_YELLOW;
            SIDE_YELLOW: if (timer == YELLOW_LAST) state_next = ALL_RED_M;
            default:     state_next = ALL_RED_M;
        endcase

        // Main green holds its timer at the minimum so the exit check stays armed
        if (state_next != state)
            timer_next = '0;
        else if (state == MAIN_GREEN && timer == MIN_GREEN_LAST)
            timer_next = timer;

        if (state_next == PED_WALK && state != PED_WALK)
            ped_next = 1'b0;
        else if (ped_req && state != PED_WALK)
            ped_next = 1'b1;

        case (state_next)
            MAIN_GREEN:  main_next = 3'b001;
            MAIN_YELLOW: main_next = 3'b010;
            SIDE_GREEN:  side_next = 3'b001;
            SIDE_YELLOW: side_next = 3'b010;
            PED_WALK:    walk_next = 1'b1;
            default:     ;
        endcase
    end

    assign phase = state;

endmodule
